// File: rtl/memap_cmd_seq_if.sv
// Command / response / downstream-access bundle for memap_cmd_seq.
// slave = sequencer side, master = command source plus downstream access port.
interface memap_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [31:0] ap_addr;
  logic [31:0] ap_data;
  logic        ap_start_read;
  logic        ap_start_write;
  logic        ap_busy;
  logic [31:0] ap_res;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rsp_ready, ap_busy, ap_res,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, ap_addr, ap_data,
           ap_start_read, ap_start_write
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rsp_ready, ap_busy, ap_res,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, ap_addr, ap_data,
           ap_start_read, ap_start_write
  );
endinterface

// File: rtl/memap_cmd_seq.sv
// Command sequencer: one start pulse per beat, waits on ap_busy with a per-beat timeout, one response per beat.
// MEMAP_CMD_SEQ_AUTOINC_EN: commands run cmd_len+1 beats with ap_addr stepping by ADDR_STEP; otherwise one beat.
module memap_cmd_seq #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_STEP      = 4
) (
  input  logic           m00_axi_aclk,
  input  logic           m00_axi_aresetn,
  memap_cmd_seq_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state;
  logic          r_cmd_en;
  logic          r_op;
  logic          r_rsp_valid;
  logic          r_rsp_timeout;
  logic          r_start_rd;
  logic          r_start_wr;
  logic [31:0]   r_rsp_data;
  logic [31:0]   r_ap_addr;
  logic [31:0]   r_ap_data;
  logic [CW-1:0] r_cnt;

  logic          w_cmd_ready;
  logic          w_accept;
  logic          w_last;
  logic          w_next_beat;
  logic [31:0]   w_addr_nxt;

  // cmd_ready is gated live by ap_busy so a still-busy downstream is never handed a new command.
  assign w_cmd_ready = r_cmd_en & ~bus.ap_busy;
  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_next_beat = (r_state == RESP) & bus.rsp_ready & ~r_rsp_timeout & ~w_last;

`ifdef MEMAP_CMD_SEQ_AUTOINC_EN
  logic [7:0] r_beats;

  assign w_last     = (r_beats == 8'd0);
  assign w_addr_nxt = r_ap_addr + 32'(ADDR_STEP);

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_beats <= 8'd0;
    end else if (w_accept) begin
      r_beats <= bus.cmd_len;
    end else if (w_next_beat) begin
      r_beats <= r_beats - 8'd1;
    end
  end
`else
  logic [7:0]  w_unused_len;
  logic [31:0] w_unused_step;

  assign w_unused_len  = bus.cmd_len;
  assign w_unused_step = 32'(ADDR_STEP);
  assign w_last        = 1'b1;
  assign w_addr_nxt    = r_ap_addr;
`endif

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state       <= IDLE;
      r_cmd_en      <= 1'b0;
      r_op          <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_start_rd    <= 1'b0;
      r_start_wr    <= 1'b0;
      r_rsp_data    <= 32'd0;
      r_ap_addr     <= 32'd0;
      r_ap_data     <= 32'd0;
      r_cnt         <= '0;
    end else begin
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_en <= 1'b1;
          if (w_accept) begin
            r_cmd_en   <= 1'b0;
            r_op       <= bus.cmd_op;
            r_ap_addr  <= bus.cmd_addr;
            r_ap_data  <= bus.cmd_data;
            r_start_rd <= ~bus.cmd_op;
            r_start_wr <= bus.cmd_op;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (!bus.ap_busy) begin
            r_rsp_data    <= r_op ? 32'd0 : bus.ap_res;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_data    <= 32'd0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            // A timed-out beat ends the whole command; remaining beats are dropped.
            if (w_next_beat) begin
              r_ap_addr  <= w_addr_nxt;
              r_start_rd <= ~r_op;
              r_start_wr <= r_op;
              r_state    <= ISSUE;
            end else begin
              r_cmd_en <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_data       = r_rsp_data;
  assign bus.rsp_timeout    = r_rsp_timeout;
  assign bus.ap_addr        = r_ap_addr;
  assign bus.ap_data        = r_ap_data;
  assign bus.ap_start_read  = r_start_rd;
  assign bus.ap_start_write = r_start_wr;

endmodule

// File: tb/tb_memap_cmd_seq.sv
// Bench for memap_cmd_seq: a downstream busy model plus a response scoreboard, one task per scenario.
module tb_memap_cmd_seq;
  typedef struct packed {
    logic [31:0] d;
    logic        t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  memap_cmd_seq_if bus();

  memap_cmd_seq #(.TIMEOUT_CYCLES(8), .ADDR_STEP(4)) dut (
    .m00_axi_aclk   (clk),
    .m00_axi_aresetn(rst_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0, n_rsp = 0, n_starts = 0, n_rd = 0, n_wr = 0;
  int start_cyc = 0, rsp_cyc = 0, fall_cyc = 0, acc_cyc = 0;
  int busy_cycles = 0, busy_left = 0, rel_tok = 0, rel_seen = 0;
  logic        busy_prev  = 1'b0;
  logic [31:0] last_wdata = 32'd0;
  exp_t        mon_e;
  exp_t        q_exp[$];
  logic [31:0] q_addr[$];

`ifdef MEMAP_CMD_SEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  always @(posedge clk) cyc = cyc + 1;

  // Downstream model: busy for busy_cycles after each start pulse; rel_tok forces busy low.
  always @(posedge clk) begin
    #2;
    if (rel_tok != rel_seen) begin
      rel_seen  = rel_tok;
      busy_left = 0;
    end
    if (bus.ap_start_read || bus.ap_start_write) begin
      n_starts++;
      if (bus.ap_start_read)  n_rd++;
      if (bus.ap_start_write) n_wr++;
      start_cyc  = cyc;
      last_wdata = bus.ap_data;
      q_addr.push_back(bus.ap_addr);
      busy_left  = busy_cycles;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    bus.ap_busy = (busy_left > 0);
    if (busy_prev && !bus.ap_busy) fall_cyc = cyc;
    busy_prev = bus.ap_busy;
  end

  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      rsp_cyc = cyc;
      n_vec++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got data=%h timeout=%b, expected no response", bus.rsp_data, bus.rsp_timeout);
      end else begin
        mon_e = q_exp.pop_front();
        if (bus.rsp_data !== mon_e.d || bus.rsp_timeout !== mon_e.t) begin
          n_err++;
          $display("FAIL rsp_payload: got data=%h timeout=%b, expected data=%h timeout=%b",
                   bus.rsp_data, bus.rsp_timeout, mon_e.d, mon_e.t);
        end
      end
    end
  end

  task automatic send_cmd(input logic op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [7:0] len);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    acc_cyc       = cyc;
    bus.cmd_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL cmd_accept: cmd_ready=%b after 200 cycles, expected 1", bus.cmd_ready);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget && n_rsp < target; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_vec++;
    if (n_rsp !== target) begin
      n_err++;
      $display("FAIL rsp_count: got %0d responses, expected %0d", n_rsp, target);
    end
  endtask

  task automatic check_addr(input logic [31:0] exp_a);
    logic [31:0] a;
    n_vec++;
    if (q_addr.size() == 0) begin
      n_err++;
      $display("FAIL beat_addr: no start pulse recorded, expected addr %h", exp_a);
    end else begin
      a = q_addr.pop_front();
      if (a !== exp_a) begin
        n_err++;
        $display("FAIL beat_addr: got %h, expected %h", a, exp_a);
      end
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b, expected 0 0", bus.cmd_ready, bus.rsp_valid);
    end
    n_vec++;
    if (bus.rsp_data !== 32'd0 || bus.rsp_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rsp: data=%h timeout=%b, expected 0 0", bus.rsp_data, bus.rsp_timeout);
    end
    n_vec++;
    if (bus.ap_addr !== 32'd0 || bus.ap_data !== 32'd0 || bus.ap_start_read !== 1'b0 || bus.ap_start_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ap: addr=%h data=%h rd=%b wr=%b, expected all 0",
               bus.ap_addr, bus.ap_data, bus.ap_start_read, bus.ap_start_write);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: cmd_ready=%b, expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read;
    int b0 = n_rsp, r0 = n_rd;
    bus.ap_res  = 32'hDEADBEEF;
    busy_cycles = 3;
    q_exp.push_back({32'hDEADBEEF, 1'b0});
    send_cmd(1'b0, 32'h4000_0000, 32'h0, 8'd0);
    wait_rsp(b0 + 1, 100);
    n_vec++;
    if (n_rd - r0 !== 1) begin
      n_err++;
      $display("FAIL read_pulses: got %0d read starts, expected 1", n_rd - r0);
    end
    check_addr(32'h4000_0000);
    n_vec++;
    if (start_cyc !== acc_cyc) begin
      n_err++;
      $display("FAIL start_latency: start in cycle %0d, expected %0d", start_cyc, acc_cyc);
    end
    n_vec++;
    if (rsp_cyc !== fall_cyc + 1) begin
      n_err++;
      $display("FAIL rsp_latency: rsp_valid in cycle %0d, expected %0d", rsp_cyc, fall_cyc + 1);
    end
  endtask

  task automatic test_write;
    int b0 = n_rsp, w0 = n_wr, s0 = n_starts;
    bus.ap_res  = 32'hAAAA5555;
    busy_cycles = 2;
    q_exp.push_back({32'd0, 1'b0});
    send_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 8'd0);
    wait_rsp(b0 + 1, 100);
    n_vec++;
    if (n_wr - w0 !== 1 || n_starts - s0 !== 1) begin
      n_err++;
      $display("FAIL write_pulses: got %0d write of %0d starts, expected 1 of 1", n_wr - w0, n_starts - s0);
    end
    check_addr(32'h0000_0010);
    n_vec++;
    if (last_wdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL write_data: got %h, expected 12345678", last_wdata);
    end
  endtask

  task automatic test_timeout;
    int b0 = n_rsp, s0 = n_starts;
    bus.ap_res  = 32'h5A5A5A5A;
    busy_cycles = 1000;
    q_exp.push_back({32'd0, 1'b1});
    send_cmd(1'b0, 32'h0000_0300, 32'h0, 8'd2);
    wait_rsp(b0 + 1, 100);
    n_vec++;
    if (rsp_cyc - start_cyc !== 9) begin
      n_err++;
      $display("FAIL timeout_latency: response %0d cycles after start, expected 9", rsp_cyc - start_cyc);
    end
    n_vec++;
    if (n_starts - s0 !== 1) begin
      n_err++;
      $display("FAIL timeout_abort: got %0d starts, expected 1", n_starts - s0);
    end
    check_addr(32'h0000_0300);
    n_vec++;
    if (bus.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_while_busy: cmd_ready=%b, expected 0", bus.cmd_ready);
    end
    rel_tok++;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_busy: cmd_ready=%b, expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_backpressure;
    int b0 = n_rsp, s0 = n_starts;
    int nb = AUTOINC ? 2 : 1;
    bit seen = 1'b0;
    bus.ap_res    = 32'h0BADF00D;
    busy_cycles   = 1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < nb; i++) q_exp.push_back({32'h0BADF00D, 1'b0});
    send_cmd(1'b0, 32'h0000_0200, 32'h0, 8'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL bp_valid: rsp_valid=%b after 50 cycles, expected 1", bus.rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0BADF00D || bus.ap_addr !== 32'h200 ||
          n_starts - s0 !== 1) begin
        n_err++;
        $display("FAIL bp_hold: valid=%b data=%h addr=%h starts=%0d, expected 1 0badf00d 00000200 1",
                 bus.rsp_valid, bus.rsp_data, bus.ap_addr, n_starts - s0);
      end
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_rsp(b0 + nb, 200);
    check_addr(32'h0000_0200);
    if (AUTOINC) check_addr(32'h0000_0204);
  endtask

  task automatic test_autoinc;
    int b0 = n_rsp, s0 = n_starts;
    int nb = AUTOINC ? 3 : 1;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFFC;
    exp_a[1] = 32'h0000_0000;
    exp_a[2] = 32'h0000_0004;
    bus.ap_res  = 32'h1111_2222;
    busy_cycles = 2;
    for (int i = 0; i < nb; i++) q_exp.push_back({32'h1111_2222, 1'b0});
    send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 8'd2);
    wait_rsp(b0 + nb, 300);
    n_vec++;
    if (n_starts - s0 !== nb) begin
      n_err++;
      $display("FAIL autoinc_beats: got %0d starts, expected %0d", n_starts - s0, nb);
    end
    for (int i = 0; i < nb; i++) check_addr(exp_a[i]);
  endtask

  task automatic test_back_to_back;
    logic        op;
    logic [31:0] addr, data, res;
    for (int k = 0; k < 6; k++) begin
      op          = 1'($urandom_range(0, 1));
      addr        = $urandom & 32'hFFFF_FFFC;
      data        = $urandom;
      res         = $urandom;
      busy_cycles = $urandom_range(0, 3);
      bus.ap_res  = res;
      q_exp.push_back({op ? 32'd0 : res, 1'b0});
      send_cmd(op, addr, data, 8'd0);
      wait_rsp(n_rsp + 1, 100);
      check_addr(addr);
      if (op) begin
        n_vec++;
        if (last_wdata !== data) begin
          n_err++;
          $display("FAIL b2b_wdata: got %h, expected %h", last_wdata, data);
        end
      end
    end
  endtask

  task automatic test_reset_midop;
    int b0 = n_rsp;
    busy_cycles = 1000;
    send_cmd(1'b0, 32'h0000_0400, 32'h0, 8'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.ap_addr !== 32'd0 || bus.ap_data !== 32'd0 || bus.cmd_ready !== 1'b0 ||
        bus.ap_start_read !== 1'b0 || bus.rsp_data !== 32'd0) begin
      n_err++;
      $display("FAIL midop_reset: valid=%b addr=%h data=%h ready=%b rd=%b rdata=%h, expected all 0",
               bus.rsp_valid, bus.ap_addr, bus.ap_data, bus.cmd_ready, bus.ap_start_read, bus.rsp_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midop_ready_busy: cmd_ready=%b, expected 0", bus.cmd_ready);
    end
    rel_tok++;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midop_ready_idle: cmd_ready=%b, expected 1", bus.cmd_ready);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (n_rsp !== b0) begin
      n_err++;
      $display("FAIL midop_no_rsp: got %0d responses, expected %0d", n_rsp, b0);
    end
    check_addr(32'h0000_0400);
    busy_cycles = 1;
    bus.ap_res  = 32'hCAFE_F00D;
    q_exp.push_back({32'hCAFE_F00D, 1'b0});
    send_cmd(1'b0, 32'h0000_0080, 32'h0, 8'd0);
    wait_rsp(b0 + 1, 100);
    check_addr(32'h0000_0080);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_data  = 32'd0;
    bus.cmd_len   = 8'd0;
    bus.rsp_ready = 1'b1;
    bus.ap_res    = 32'd0;
    test_reset;
    test_read;
    test_write;
    test_timeout;
    test_backpressure;
    test_autoinc;
    test_back_to_back;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/memap_cmd_seq.md
MEMAP_CMD_SEQ -- requirements
Module: memap_cmd_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max cycles ap_busy may stay high per beat before timeout.
REQ-002 SHALL have parameter ADDR_STEP, default 4: address increment per beat (AUTOINC only).
REQ-003 SHALL have port m00_axi_aclk  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port m00_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 SHALL have ports cmd_op in 1 (0=read, 1=write), cmd_addr in 32, cmd_data in 32, cmd_len in 8 (beats minus one).
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-008 SHALL have ports rsp_data out 32 (read data, 0 for writes) and rsp_timeout out 1.
REQ-009 SHALL have ports ap_addr out 32, ap_data out 32, ap_start_read out 1, ap_start_write out 1: downstream single-access port.
REQ-010 SHALL have ports ap_busy in 1, ap_res in 32: downstream status and read result.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 cmd_ready SHALL be 1 only in IDLE with ap_busy=0; command accepted on cmd_valid&cmd_ready.
REQ-013 Accept SHALL latch op/addr/data/len and move to ISSUE on the next edge.
REQ-014 ISSUE SHALL last exactly one cycle, asserting ap_start_read (op=0) or ap_start_write (op=1) for that cycle only, then enter WAIT.
REQ-015 ap_addr/ap_data SHALL be registered, stable from ISSUE until the beat's response is accepted.
REQ-016 WAIT SHALL, on the first cycle with ap_busy=0, register ap_res (read) or 0 (write) into rsp_data, clear rsp_timeout, enter RESP.
REQ-017 Latency SHALL be: start pulse 1 cycle after accept; rsp_valid 1 cycle after first ap_busy=0 in WAIT.
REQ-018 A per-beat counter SHALL clear in ISSUE and increment each WAIT cycle; at TIMEOUT_CYCLES with ap_busy=1 SHALL enter RESP with rsp_timeout=1, rsp_data=0.
REQ-019 RESP SHALL hold rsp_valid=1 and rsp_data/rsp_timeout stable until rsp_ready=1; rsp_ready with rsp_valid=0 SHALL be ignored.
REQ-020 On RESP handshake: if timeout occurred or no beats remain -> IDLE; else -> ISSUE for next beat.
REQ-021 A timed-out command SHALL abort remaining beats; IDLE then waits for ap_busy=0 before cmd_ready.
REQ-022 cmd_valid during non-IDLE states SHALL be ignored (cmd_ready=0).

Reset
REQ-023 On m00_axi_aresetn=0, immediately: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, ap_start_read=0, ap_start_write=0, ap_addr=0, ap_data=0, counters=0.
REQ-024 Reset mid-operation SHALL discard the command without emitting a response; cmd_ready returns once reset released and ap_busy=0.

Configuration
REQ-025 Macro MEMAP_CMD_SEQ_AUTOINC_EN defined: command executes cmd_len+1 beats, ap_addr += ADDR_STEP per beat (mod 2^32 wrap), one response per beat, same cmd_data every write beat.
REQ-026 Macro undefined: cmd_len ignored, exactly one beat and one response per command; no beat counter logic.

Verification
REQ-027 Read addr 0x40000000, ap_busy high 3 cycles after start, ap_res=0xDEADBEEF -> one ap_start_read pulse, rsp_data=0xDEADBEEF, rsp_timeout=0.
REQ-028 Write addr 0x10, data 0x12345678 -> one ap_start_write pulse, ap_data=0x12345678, rsp_data=0, rsp_timeout=0.
REQ-029 Read with ap_busy stuck high, TIMEOUT_CYCLES=8 -> rsp_valid after 8 WAIT cycles, rsp_timeout=1, rsp_data=0; cmd_ready stays 0 until ap_busy falls.
REQ-030 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable; no new start pulse until handshake.
REQ-031 AUTOINC_EN, read addr 0xFFFFFFFC, cmd_len=2 -> ap_addr 0xFFFFFFFC, 0x00000000, 0x00000004; three responses; without macro one response.
REQ-032 Reset asserted in WAIT -> outputs zero immediately, no response after release, next command executes normally.
